// File: rtl/bsg_cache_to_dram_ctrl_tx_gearbox.sv
// Write-data path from num_cache_p cache DMA ports to a DRAM controller write-data FIFO.
// A tag FIFO orders pending writebacks; for the head tag, cache words are packed
// (word 0 in the LSBs) into dram_data_width_p beats and sent with burst end framing.
module bsg_cache_to_dram_ctrl_tx_gearbox #(
  parameter int unsigned num_cache_p           = 2,
  parameter int unsigned data_width_p          = 32,
  parameter int unsigned dram_data_width_p     = 64,
  parameter int unsigned block_size_in_words_p = 8,
  parameter int unsigned dram_ctrl_burst_len_p = 2,
  parameter int unsigned tag_fifo_els_p        = 4,
  localparam int unsigned lg_num_cache_lp      = (num_cache_p > 1) ? $clog2(num_cache_p) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,

  input  logic                                  v_i,
  input  logic [lg_num_cache_lp-1:0]            tag_i,
  output logic                                  ready_o,

  input  logic [num_cache_p*data_width_p-1:0]   dma_data_i,
  input  logic [num_cache_p-1:0]                dma_data_v_i,
  output logic [num_cache_p-1:0]                dma_data_yumi_o,

  output logic                                  app_wdf_wren_o,
  output logic [dram_data_width_p-1:0]          app_wdf_data_o,
  output logic [dram_data_width_p/8-1:0]        app_wdf_mask_o,
  output logic                                  app_wdf_end_o,
  input  logic                                  app_wdf_rdy_i
);

  localparam int unsigned WordsPerBeat  = dram_data_width_p / data_width_p;
  localparam int unsigned BlockBeats    = block_size_in_words_p / WordsPerBeat;
  localparam int unsigned WordCntW      = (WordsPerBeat > 1) ? $clog2(WordsPerBeat) : 1;
  localparam int unsigned BeatCntW      = (dram_ctrl_burst_len_p > 1) ?
                                          $clog2(dram_ctrl_burst_len_p) : 1;
  localparam int unsigned BlockBeatCntW = (BlockBeats > 1) ? $clog2(BlockBeats) : 1;
  localparam int unsigned PtrW          = $clog2(tag_fifo_els_p);

  localparam logic [WordCntW-1:0]      WordCntMax      = WordCntW'(WordsPerBeat - 1);
  localparam logic [BeatCntW-1:0]      BeatCntMax      = BeatCntW'(dram_ctrl_burst_len_p - 1);
  localparam logic [BlockBeatCntW-1:0] BlockBeatCntMax = BlockBeatCntW'(BlockBeats - 1);

  typedef enum logic [0:0] {StFill, StSend} state_e;

  // ---------------------------------------------------------------------------
  // Tag FIFO: pointers carry one extra wrap bit to tell full from empty.
  // ---------------------------------------------------------------------------
  logic [lg_num_cache_lp-1:0] tag_mem_q [tag_fifo_els_p];
  logic [PtrW:0]              wptr_q, rptr_q;
  logic                       fifo_empty, fifo_full;
  logic                       enq, deq;
  logic [lg_num_cache_lp-1:0] head_tag;
  logic                       tag_v;

  state_e                     state_q;
  logic [WordCntW-1:0]        word_cnt_q;
  logic [BeatCntW-1:0]        beat_cnt_q;
  logic [BlockBeatCntW-1:0]   block_beat_cnt_q;
  logic [dram_data_width_p-1:0] beat_q;

  logic                       beat_last, block_last;
  logic                       yumi_any;
  logic [data_width_p-1:0]    sel_word;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                      (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  // Held low during reset so the requester never sees a spurious ready.
  assign ready_o    = ~fifo_full & ~reset_i;
  assign enq        = v_i & ready_o;
  assign head_tag   = tag_mem_q[rptr_q[PtrW-1:0]];
  assign tag_v      = ~fifo_empty;

  assign beat_last  = (beat_cnt_q == BeatCntMax);
  assign block_last = (block_beat_cnt_q == BlockBeatCntMax);
  assign deq        = (state_q == StSend) & app_wdf_rdy_i & block_last;

  // Tag storage needs no reset: entries are only read between enq and deq.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      tag_mem_q[wptr_q[PtrW-1:0]] <= tag_i;
    end
  end

  // FIFO pointers; wrap modulo depth falls out of the power-of-two width.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (enq) wptr_q <= wptr_q + 1'b1;
      if (deq) rptr_q <= rptr_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Cache selection. Comparing against each legal index means an out-of-range
  // tag matches nothing, so it never produces a yumi.
  // ---------------------------------------------------------------------------
  // Consume a word from the head-tag cache only while filling a beat.
  always_comb begin
    dma_data_yumi_o = '0;
    for (int unsigned c = 0; c < num_cache_p; c++) begin
      dma_data_yumi_o[c] = (state_q == StFill) && tag_v &&
                           (head_tag == lg_num_cache_lp'(c)) && dma_data_v_i[c];
    end
  end

  // Mux the selected cache's word onto the packing path.
  always_comb begin
    sel_word = '0;
    for (int unsigned c = 0; c < num_cache_p; c++) begin
      if (head_tag == lg_num_cache_lp'(c)) begin
        sel_word = dma_data_i[c*data_width_p +: data_width_p];
      end
    end
  end

  assign yumi_any = |dma_data_yumi_o;

  // ---------------------------------------------------------------------------
  // Fill/send FSM with packing register and beat/burst/block counters.
  // ---------------------------------------------------------------------------
  // FILL packs words into beat_q; SEND presents beat_q until the DRAM FIFO takes it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q          <= StFill;
      word_cnt_q       <= '0;
      beat_cnt_q       <= '0;
      block_beat_cnt_q <= '0;
      beat_q           <= '0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (yumi_any) begin
            for (int unsigned w = 0; w < WordsPerBeat; w++) begin
              if (word_cnt_q == WordCntW'(w)) begin
                beat_q[w*data_width_p +: data_width_p] <= sel_word;
              end
            end
            if (word_cnt_q == WordCntMax) begin
              word_cnt_q <= '0;
              state_q    <= StSend;
            end else begin
              word_cnt_q <= word_cnt_q + 1'b1;
            end
          end
        end
        StSend: begin
          if (app_wdf_rdy_i) begin
            state_q <= StFill;
            if (block_last) begin
              // End of block: the tag is dequeued, so restart all framing.
              beat_cnt_q       <= '0;
              block_beat_cnt_q <= '0;
              word_cnt_q       <= '0;
            end else begin
              beat_cnt_q       <= beat_last ? '0 : beat_cnt_q + 1'b1;
              block_beat_cnt_q <= block_beat_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  assign app_wdf_wren_o = (state_q == StSend);
  assign app_wdf_end_o  = (state_q == StSend) & beat_last;
  assign app_wdf_data_o = beat_q;
  assign app_wdf_mask_o = '0;

endmodule

// File: tb/tb_bsg_cache_to_dram_ctrl_tx_gearbox.sv
// Directed bench for the cache-to-DRAM tx gearbox: default config (dut_a) and a
// 32-bit / burst-4 / block-4 config (dut_b). Expected beats are built from the
// known word values each cache supplies.
`timescale 1ns/1ps
module tb_bsg_cache_to_dram_ctrl_tx_gearbox;

  localparam int unsigned NC = 2;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // dut_a: defaults
  logic             v_a, ready_a, wren_a, end_a, rdy_a;
  logic [0:0]       tag_a;
  logic [NC*DW-1:0] dmad_a;
  logic [NC-1:0]    dmav_a, yumi_a;
  logic [63:0]      data_a;
  logic [7:0]       mask_a;

  // dut_b: dram width 32, burst 4, block 4
  logic             v_b, ready_b, wren_b, end_b, rdy_b;
  logic [0:0]       tag_b;
  logic [NC*DW-1:0] dmad_b;
  logic [NC-1:0]    dmav_b, yumi_b;
  logic [31:0]      data_b;
  logic [3:0]       mask_b;

  bsg_cache_to_dram_ctrl_tx_gearbox dut_a (
    .clk_i           (clk),
    .reset_i         (reset),
    .v_i             (v_a),
    .tag_i           (tag_a),
    .ready_o         (ready_a),
    .dma_data_i      (dmad_a),
    .dma_data_v_i    (dmav_a),
    .dma_data_yumi_o (yumi_a),
    .app_wdf_wren_o  (wren_a),
    .app_wdf_data_o  (data_a),
    .app_wdf_mask_o  (mask_a),
    .app_wdf_end_o   (end_a),
    .app_wdf_rdy_i   (rdy_a)
  );

  bsg_cache_to_dram_ctrl_tx_gearbox #(
    .dram_data_width_p     (32),
    .dram_ctrl_burst_len_p (4),
    .block_size_in_words_p (4)
  ) dut_b (
    .clk_i           (clk),
    .reset_i         (reset),
    .v_i             (v_b),
    .tag_i           (tag_b),
    .ready_o         (ready_b),
    .dma_data_i      (dmad_b),
    .dma_data_v_i    (dmav_b),
    .dma_data_yumi_o (yumi_b),
    .app_wdf_wren_o  (wren_b),
    .app_wdf_data_o  (data_b),
    .app_wdf_mask_o  (mask_b),
    .app_wdf_end_o   (end_b),
    .app_wdf_rdy_i   (rdy_b)
  );

  int n_vec = 0;
  int n_err = 0;

  // Per-cache word index for the next word each cache presents.
  int unsigned wa [NC];
  int unsigned wb [NC];

  logic [63:0] beats_a [$];
  logic        ends_a  [$];
  logic [31:0] beats_b [$];
  logic        ends_b  [$];
  int          yumi_cnt_a [NC];
  int          yumi_cnt_b [NC];
  int          bad_yumi;
  int          ready_low_cnt;
  int          wren_cnt_a;

  // Last sampled values of dut_a.
  logic        s_ready, s_wren, s_end;
  logic [63:0] s_data;
  logic [NC-1:0] s_yumi;

  // Cache 1 supplies plain indices; cache 0 is tagged in the top nibble.
  function automatic logic [31:0] word_val(input int c, input int unsigned i);
    return (c == 0) ? (32'hC000_0000 | 32'(i)) : 32'(i);
  endfunction

  function automatic logic [63:0] exp_beat(input int c, input int unsigned idx);
    return {word_val(c, idx + 1), word_val(c, idx)};
  endfunction

  function automatic logic [63:0] get_a(input int i);
    return (i < beats_a.size()) ? beats_a[i] : 64'hEEEE_EEEE_EEEE_EEEE;
  endfunction

  function automatic logic [63:0] get_end_a(input int i);
    return (i < ends_a.size()) ? 64'(ends_a[i]) : 64'hEEEE;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < NC; c++) begin
      dmad_a[c*DW +: DW] = word_val(c, wa[c]);
      dmad_b[c*DW +: DW] = word_val(c, wb[c]);
    end
  endtask

  task automatic clear();
    beats_a.delete(); ends_a.delete(); beats_b.delete(); ends_b.delete();
    for (int c = 0; c < NC; c++) begin
      wa[c] = 0; wb[c] = 0; yumi_cnt_a[c] = 0; yumi_cnt_b[c] = 0;
    end
    bad_yumi = 0; ready_low_cnt = 0; wren_cnt_a = 0;
    drive();
  endtask

  // One clock: sample just after the negedge (inputs settled), let the posedge
  // consume, then advance each cache's word on the following negedge.
  task automatic cyc();
    logic [NC-1:0] ya, yb;
    #1;
    s_ready = ready_a; s_wren = wren_a; s_data = data_a; s_end = end_a; s_yumi = yumi_a;
    if (!ready_a) ready_low_cnt++;
    if (wren_a) wren_cnt_a++;
    if (wren_a && rdy_a) begin beats_a.push_back(data_a); ends_a.push_back(end_a); end
    if (wren_b && rdy_b) begin beats_b.push_back(data_b); ends_b.push_back(end_b); end
    for (int c = 0; c < NC; c++) begin
      if (yumi_a[c]) yumi_cnt_a[c]++;
      if (yumi_b[c]) yumi_cnt_b[c]++;
      if (yumi_a[c] && !dmav_a[c]) bad_yumi++;
    end
    ya = yumi_a; yb = yumi_b;
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      if (ya[c]) wa[c]++;
      if (yb[c]) wb[c]++;
    end
    drive();
  endtask

  task automatic enq_a(input logic t);
    v_a = 1'b1; tag_a = t;
    cyc();
    v_a = 1'b0;
  endtask

  task automatic run_until_a(input int n, input int budget);
    for (int i = 0; i < budget && beats_a.size() < n; i++) cyc();
  endtask

  // Checks a full tag-1 or tag-0 block starting at word 0 from index base.
  task automatic check_block_a(input string name, input int base, input int c);
    for (int b = 0; b < 4; b++) begin
      check_eq($sformatf("%s_beat%0d", name, b), get_a(base + b), exp_beat(c, 2 * b));
      check_eq($sformatf("%s_end%0d", name, b), get_end_a(base + b), 64'(b % 2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] held_data;
    logic        held_end;

    reset = 1'b1;
    v_a = 0; tag_a = 0; dmav_a = 0; rdy_a = 1;
    v_b = 0; tag_b = 0; dmav_b = 0; rdy_b = 1;
    clear();
    @(negedge clk);
    #1;
    check_eq("rst_ready", 64'(ready_a), 0);
    check_eq("rst_wren", 64'(wren_a), 0);
    check_eq("rst_end", 64'(end_a), 0);
    check_eq("rst_data", data_a, 0);
    @(negedge clk);
    reset = 1'b0;

    // Test 1: single block from cache 1; cache 0 valid but unselected.
    clear();
    dmav_a = 2'b11;
    cyc();
    check_eq("t1_ready_after_reset", 64'(s_ready), 1);
    enq_a(1'b1);
    cyc();
    check_eq("t1_first_yumi", 64'(s_yumi), 64'(2'b10));
    run_until_a(4, 40);
    repeat (3) cyc();
    check_eq("t1_nbeats", 64'(beats_a.size()), 4);
    check_block_a("t1", 0, 1);
    check_eq("t1_yumi1", 64'(yumi_cnt_a[1]), 8);
    check_eq("t1_yumi0", 64'(yumi_cnt_a[0]), 0);
    check_eq("t1_ready_low", 64'(ready_low_cnt), 0);
    check_eq("t1_mask", 64'(mask_a), 0);

    // Test 2: four tags fill the FIFO; blocks drain in order.
    clear();
    for (int k = 0; k < 4; k++) enq_a(k[0]);
    cyc();
    check_eq("t2_full", 64'(s_ready), 0);
    run_until_a(4, 60);
    check_eq("t2_ready_low_on_last", 64'(s_ready), 0);
    cyc();
    check_eq("t2_ready_back", 64'(s_ready), 1);
    run_until_a(16, 120);
    check_eq("t2_nbeats", 64'(beats_a.size()), 16);
    for (int i = 0; i < 16; i++) begin
      int k;
      k = i / 4;
      check_eq($sformatf("t2_beat%0d", i), get_a(i),
               exp_beat(k % 2, (k / 2) * 8 + 2 * (i % 4)));
      check_eq($sformatf("t2_end%0d", i), get_end_a(i), 64'((i % 4) % 2));
    end
    check_eq("t2_yumi0", 64'(yumi_cnt_a[0]), 16);
    check_eq("t2_yumi1", 64'(yumi_cnt_a[1]), 16);

    // Test 3: DRAM FIFO stalls for 5 cycles while beat 2 is offered.
    clear();
    enq_a(1'b0);
    run_until_a(1, 20);
    rdy_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (s_wren) break;
    end
    held_data = s_data;
    held_end  = s_end;
    check_eq("t3_stall_data", held_data, exp_beat(0, 2));
    check_eq("t3_stall_end", 64'(held_end), 1);
    check_eq("t3_stall_yumi0", 64'(s_yumi), 0);
    for (int i = 1; i < 5; i++) begin
      cyc();
      check_eq($sformatf("t3_wren%0d", i), 64'(s_wren), 1);
      check_eq($sformatf("t3_data%0d", i), s_data, held_data);
      check_eq($sformatf("t3_endh%0d", i), 64'(s_end), 64'(held_end));
      check_eq($sformatf("t3_yumi%0d", i), 64'(s_yumi), 0);
    end
    check_eq("t3_no_accept_in_stall", 64'(beats_a.size()), 1);
    rdy_a = 1'b1;
    cyc();
    check_eq("t3_accept_on_rdy", 64'(beats_a.size()), 2);
    run_until_a(4, 40);
    check_block_a("t3", 0, 0);

    // Test 4: selected cache valid toggles; other cache valid held high.
    clear();
    dmav_a = 2'b10;
    enq_a(1'b0);
    for (int i = 0; i < 80 && beats_a.size() < 4; i++) begin
      dmav_a[0] = ~dmav_a[0];
      cyc();
    end
    repeat (3) cyc();
    check_block_a("t4", 0, 0);
    check_eq("t4_yumi0", 64'(yumi_cnt_a[0]), 8);
    check_eq("t4_yumi1", 64'(yumi_cnt_a[1]), 0);
    check_eq("t4_yumi_no_valid", 64'(bad_yumi), 0);

    // Test 5: async reset mid-block with a second tag pending.
    clear();
    dmav_a = 2'b11;
    enq_a(1'b1);
    enq_a(1'b0);
    run_until_a(1, 20);
    cyc();
    #3;
    reset = 1'b1;
    #1;
    check_eq("t5_rst_wren", 64'(wren_a), 0);
    check_eq("t5_rst_end", 64'(end_a), 0);
    check_eq("t5_rst_data", data_a, 0);
    check_eq("t5_rst_yumi", 64'(yumi_a), 0);
    check_eq("t5_rst_ready", 64'(ready_a), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear();
    repeat (10) cyc();
    check_eq("t5_no_wren_after", 64'(wren_cnt_a), 0);
    check_eq("t5_no_yumi_after", 64'(yumi_cnt_a[0] + yumi_cnt_a[1]), 0);
    check_eq("t5_ready_after", 64'(s_ready), 1);
    enq_a(1'b1);
    run_until_a(4, 40);
    check_block_a("t5", 0, 1);

    // Test 6: narrow config, one burst of four single-word beats.
    clear();
    dmav_b = 2'b01;
    v_b = 1'b1; tag_b = 1'b0;
    cyc();
    v_b = 1'b0;
    for (int i = 0; i < 40 && beats_b.size() < 4; i++) cyc();
    repeat (3) cyc();
    check_eq("t6_nbeats", 64'(beats_b.size()), 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t6_beat%0d", i),
               (i < beats_b.size()) ? 64'(beats_b[i]) : 64'hEEEE, 64'(word_val(0, i)));
      check_eq($sformatf("t6_end%0d", i),
               (i < ends_b.size()) ? 64'(ends_b[i]) : 64'hEEEE, 64'(i == 3));
    end
    check_eq("t6_yumi0", 64'(yumi_cnt_b[0]), 4);
    check_eq("t6_mask", 64'(mask_b), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
